// File: rtl/fp_operand_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fp_operand_gen
//  Purpose  : Operand-pair stimulus generator for floating-point datapath
//             benches. Emits (a, b) pairs over a val/rdy handshake in one of
//             three modes: structured exponent/mantissa sweep, xorshift32
//             pseudo-random, or a directed special-value cross product.
//             Raises done when the selected sequence is exhausted.
//  Ports    : clk, rst (async, active high)
//             start  - single-cycle request to begin a sequence
//             mode   - 0 SWEEP, 1 RAND, 2/3 DIRECTED (sampled on start)
//             seed   - RAND seed (sampled on start, 0 maps to 1)
//             a, b   - operands {sign, exp, man}, width 1+EXP_W+MAN_W
//             val    - pair valid;  rdy - consumer ready
//             idx    - index of the current pair;  done - sequence complete
//  Config   : FP_GEN_DENORM_FLUSH_EN - when defined, any emitted operand with
//             a zero exponent has its mantissa forced to zero (sign kept).
//  Revision : 1.0 - initial release
// ============================================================================
module fp_operand_gen #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int RAND_N = 1024,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [31:0]            seed,
  output logic [EXP_W+MAN_W:0]   a,
  output logic [EXP_W+MAN_W:0]   b,
  output logic                   val,
  input  logic                   rdy,
  output logic [CNT_W-1:0]       idx,
  output logic                   done
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int FW = EXP_W + MAN_W;

  localparam logic [1:0]       c_mode_sweep = 2'd0;
  localparam logic [1:0]       c_mode_rand  = 2'd1;
  localparam logic [EXP_W-1:0] c_exp_zero   = '0;
  localparam logic [EXP_W-1:0] c_exp_ones   = '1;
  localparam logic [EXP_W-1:0] c_exp_bias   = {1'b0, {(EXP_W-1){1'b1}}};
  localparam logic [EXP_W-1:0] c_exp_max    = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [MAN_W-1:0] c_man_zero   = '0;
  localparam logic [MAN_W-1:0] c_man_ones   = '1;
  localparam logic [MAN_W-1:0] c_man_one    = MAN_W'(1);
  localparam logic [MAN_W-1:0] c_man_msb    = {1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] c_rand_last  = CNT_W'(RAND_N - 1);
  localparam logic [5:0]       c_dir_last   = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_mode;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [31:0]      r_s;
  logic [5:0]       r_dcnt;
  logic             r_val;
  logic             r_done;
  logic [CNT_W-1:0] r_idx;

  logic [31:0]      w_s_src;
  logic [31:0]      w_x1;
  logic [31:0]      w_x2;
  logic [FW-1:0]    w_a_step;
  logic [FW-1:0]    w_b_step;
  logic             w_a_wrap;
  logic             w_b_end;
  logic [5:0]       w_dnext;
  logic             w_xfer;
  logic             w_last;

  function automatic logic [31:0] f_xs(input logic [31:0] s_in);
    logic [31:0] s;
    s = s_in;
    s = s ^ (s << 13);
    s = s ^ (s >> 17);
    s = s ^ (s << 5);
    return s;
  endfunction

  // Shift a one into the mantissa; once it would reach the MSB, roll over
  // into the next exponent with a cleared mantissa.
  function automatic logic [FW-1:0] f_step(input logic [EXP_W-1:0] e,
                                           input logic [MAN_W-1:0] m);
    logic [MAN_W-1:0] sm;
    sm = {m[MAN_W-2:0], 1'b1};
    if (sm[MAN_W-1])
      return {e + EXP_W'(1), c_man_zero};
    else
      return {e, sm};
  endfunction

  function automatic logic [W-1:0] f_tbl(input logic [2:0] k);
    case (k)
      3'd0:    return {1'b0, c_exp_zero, c_man_zero};  // +0
      3'd1:    return {1'b1, c_exp_zero, c_man_zero};  // -0
      3'd2:    return {1'b0, c_exp_bias, c_man_zero};  // +1.0
      3'd3:    return {1'b1, c_exp_bias, c_man_zero};  // -1.0
      3'd4:    return {1'b0, c_exp_zero, c_man_one};   // min subnormal
      3'd5:    return {1'b0, c_exp_max,  c_man_ones};  // max normal
      3'd6:    return {1'b0, c_exp_ones, c_man_zero};  // +inf
      default: return {1'b0, c_exp_ones, c_man_msb};   // qNaN
    endcase
  endfunction

`ifdef FP_GEN_DENORM_FLUSH_EN
  function automatic logic [W-1:0] f_flush(input logic [W-1:0] v);
    if (v[FW-1:MAN_W] == c_exp_zero)
      return {v[W-1], FW'(0)};
    else
      return v;
  endfunction
`endif

  // The random state source is the sampled seed while idle/done (so the
  // first pair is ready the cycle after start) and the running state after.
  always_comb begin
    w_s_src  = r_s;
    if (r_state != ST_RUN)
      w_s_src = (seed == 32'd0) ? 32'd1 : seed;
    w_x1     = f_xs(w_s_src);
    w_x2     = f_xs(w_x1);
    w_a_step = f_step(r_a[FW-1:MAN_W], r_a[MAN_W-1:0]);
    w_b_step = f_step(r_b[FW-1:MAN_W], r_b[MAN_W-1:0]);
    w_a_wrap = &w_a_step[FW-1:MAN_W];
    w_b_end  = &w_b_step[FW-1:MAN_W];
    w_dnext  = r_dcnt + 6'd1;
    w_xfer   = r_val && rdy;
    case (r_mode)
      c_mode_sweep: w_last = w_a_wrap && w_b_end;
      c_mode_rand:  w_last = (r_idx == c_rand_last);
      default:      w_last = (r_dcnt == c_dir_last);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= 2'd0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= 32'd1;
      r_dcnt  <= 6'd0;
      r_val   <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_mode  <= mode;
            r_val   <= 1'b1;
            r_done  <= 1'b0;
            r_idx   <= '0;
            r_dcnt  <= 6'd0;
            case (mode)
              c_mode_sweep: begin
                r_a <= '0;
                r_b <= '0;
              end
              c_mode_rand: begin
                r_a <= w_x1[W-1:0];
                r_b <= w_x2[W-1:0];
                r_s <= w_x2;
              end
              default: begin
                r_a <= f_tbl(3'd0);
                r_b <= f_tbl(3'd0);
              end
            endcase
          end
        end
        ST_RUN: begin
          if (w_xfer) begin
            if (w_last) begin
              r_state <= ST_DONE;
              r_val   <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + CNT_W'(1);
              case (r_mode)
                c_mode_sweep: begin
                  // a wraps through every finite exponent, flipping its sign
                  // each pass, before b takes one step.
                  if (w_a_wrap) begin
                    r_a <= {~r_a[W-1], FW'(0)};
                    r_b <= {r_b[W-1], w_b_step};
                  end else begin
                    r_a <= {r_a[W-1], w_a_step};
                  end
                end
                c_mode_rand: begin
                  r_a <= w_x1[W-1:0];
                  r_b <= w_x2[W-1:0];
                  r_s <= w_x2;
                end
                default: begin
                  r_dcnt <= w_dnext;
                  r_a    <= f_tbl(w_dnext[5:3]);
                  r_b    <= f_tbl(w_dnext[2:0]);
                end
              endcase
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Flushing is applied on the way out so the sweep walk itself is never
  // disturbed and sequence lengths stay identical.
`ifdef FP_GEN_DENORM_FLUSH_EN
  assign a = f_flush(r_a);
  assign b = f_flush(r_b);
`else
  assign a = r_a;
  assign b = r_b;
`endif
  assign val  = r_val;
  assign done = r_done;
  assign idx  = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_fp_operand_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_operand_gen
//  Purpose  : Directed self-checking bench for fp_operand_gen. One instance
//             uses default fp32 parameters, a second uses EXP_W=3, MAN_W=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_operand_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        g_start = 1'b0;
  logic [1:0]  g_mode  = 2'd0;
  logic [31:0] g_seed  = 32'd0;
  logic        g_rdy   = 1'b0;
  logic [31:0] g_a, g_b, g_idx;
  logic        g_val, g_done;

  logic        s_start = 1'b0;
  logic [1:0]  s_mode  = 2'd0;
  logic [31:0] s_seed  = 32'd0;
  logic        s_rdy   = 1'b0;
  logic [5:0]  s_a, s_b;
  logic [15:0] s_idx;
  logic        s_val, s_done;

  int errors = 0;
  int checks = 0;

  fp_operand_gen u_big (
    .clk(clk), .rst(rst), .start(g_start), .mode(g_mode), .seed(g_seed),
    .a(g_a), .b(g_b), .val(g_val), .rdy(g_rdy), .idx(g_idx), .done(g_done)
  );

  fp_operand_gen #(.EXP_W(3), .MAN_W(2), .RAND_N(4), .CNT_W(16)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .seed(s_seed),
    .a(s_a), .b(s_b), .val(s_val), .rdy(s_rdy), .idx(s_idx), .done(s_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent fp32 special-value table.
  logic [31:0] dir_tbl [8];
  logic [31:0] sw_first [4];

  initial begin
    int cnt, cyc, last_idx;
    logic [5:0]  last_sa, last_sb;
    logic [31:0] pa, pb, pidx;
    logic        hold, pulsed;
    logic [5:0]  di;

    dir_tbl[0] = 32'h00000000; dir_tbl[1] = 32'h80000000;
    dir_tbl[2] = 32'h3F800000; dir_tbl[3] = 32'hBF800000;
`ifdef FP_GEN_DENORM_FLUSH_EN
    dir_tbl[4] = 32'h00000000;
`else
    dir_tbl[4] = 32'h00000001;
`endif
    dir_tbl[5] = 32'h7F7FFFFF; dir_tbl[6] = 32'h7F800000;
    dir_tbl[7] = 32'h7FC00000;
    sw_first[0] = 32'h00; sw_first[1] = 32'h01;
    sw_first[2] = 32'h04; sw_first[3] = 32'h05;

    // ---- reset state and idle period ----
    tick(); tick();
    chk("rst_a", g_a, 32'h0);
    chk("rst_b", g_b, 32'h0);
    chk("rst_val", 32'(g_val), 32'h0);
    chk("rst_idx", g_idx, 32'h0);
    chk("rst_done", 32'(g_done), 32'h0);
    chk("rst_small_val", 32'(s_val), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_val", 32'(g_val), 32'h0);
      chk("idle_done", 32'(g_done), 32'h0);
      chk("idle_a", g_a, 32'h0);
      chk("idle_b", g_b, 32'h0);
    end

    // ---- small SWEEP, always ready ----
    s_rdy = 1'b1; s_mode = 2'd0; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("sweep_first_b", 32'(s_b), 32'h0);
    cnt = 0; cyc = 0; last_sa = '0; last_sb = '0;
    while (s_val === 1'b1 && cyc < 400) begin
      if (cnt < 4) chk("sweep_first_a", 32'(s_a), sw_first[cnt]);
      if (cnt == 13) chk("sweep_pre_wrap_a", 32'(s_a), 32'h19);
      if (cnt == 14) begin
        chk("sweep_wrap_a", 32'(s_a), 32'h20);
        chk("sweep_wrap_b", 32'(s_b), 32'h01);
      end
      chk("sweep_idx", 32'(s_idx), 32'(cnt));
      last_sa = s_a; last_sb = s_b;
      cnt++; cyc++;
      tick();
    end
    chk("sweep_count", 32'(cnt), 32'd196);
    chk("sweep_last_a", 32'(last_sa), 32'h39);
    chk("sweep_last_b", 32'(last_sb), 32'h19);
    chk("sweep_done", 32'(s_done), 32'h1);
    chk("sweep_val_end", 32'(s_val), 32'h0);

    // ---- RAND, seed 0, with a short stall first ----
    g_mode = 2'd1; g_seed = 32'd0; g_rdy = 1'b0; g_start = 1'b1;
    tick();
    g_start = 1'b0;
    chk("rand0_val", 32'(g_val), 32'h1);
    chk("rand0_a", g_a, 32'h00042021);
    chk("rand0_b", g_b, 32'h04080601);
    chk("rand0_idx", g_idx, 32'h0);
    tick(); tick();
    chk("rand0_stall_a", g_a, 32'h00042021);
    chk("rand0_stall_b", g_b, 32'h04080601);
    chk("rand0_stall_idx", g_idx, 32'h0);
    g_rdy = 1'b1;
    cnt = 0; cyc = 0; last_idx = -1;
    while (g_val === 1'b1 && cyc < 1100) begin
      last_idx = int'(g_idx);
      cnt++; cyc++;
      tick();
    end
    chk("rand0_count", 32'(cnt), 32'd1024);
    chk("rand0_last_idx", 32'(last_idx), 32'd1023);
    chk("rand0_done", 32'(g_done), 32'h1);

    // ---- RAND, seed 1, restarted from DONE ----
    g_seed = 32'd1; g_start = 1'b1;
    tick();
    g_start = 1'b0;
    chk("rand1_a", g_a, 32'h00042021);
    chk("rand1_b", g_b, 32'h04080601);
    chk("rand1_done_clr", 32'(g_done), 32'h0);
    chk("rand1_idx", g_idx, 32'h0);
    cyc = 0;
    while (g_val === 1'b1 && cyc < 1100) begin cyc++; tick(); end
    chk("rand1_done", 32'(g_done), 32'h1);

    // ---- DIRECTED with random ready and an ignored mid-run start ----
    g_mode = 2'd2; g_start = 1'b1; g_rdy = 1'b0;
    tick();
    g_start = 1'b0;
    cnt = 0; cyc = 0; hold = 1'b0; pulsed = 1'b0;
    pa = '0; pb = '0; pidx = '0;
    while (g_val === 1'b1 && cyc < 2000) begin
      g_start = 1'b0;
      if (hold) begin
        chk("dir_hold_a", g_a, pa);
        chk("dir_hold_b", g_b, pb);
        chk("dir_hold_idx", g_idx, pidx);
      end
      di = g_idx[5:0];
      chk("dir_idx", g_idx, 32'(cnt));
      chk("dir_a", g_a, dir_tbl[di[5:3]]);
      chk("dir_b", g_b, dir_tbl[di[2:0]]);
      if (g_idx == 32'h2E) begin
        chk("dir_pair2e_a", g_a, 32'h7F7FFFFF);
        chk("dir_pair2e_b", g_b, 32'h7F800000);
      end
      if (g_idx == 32'h16) begin
        chk("dir_pair16_a", g_a, 32'h3F800000);
        chk("dir_pair16_b", g_b, 32'h7F800000);
      end
`ifdef FP_GEN_DENORM_FLUSH_EN
      if (g_idx == 32'h24) chk("dir_pair24_a", g_a, 32'h00000000);
`else
      if (g_idx == 32'h24) chk("dir_pair24_a", g_a, 32'h00000001);
`endif
      if (cnt == 10 && !pulsed) begin
        g_start = 1'b1; g_mode = 2'd0; pulsed = 1'b1;
      end
      g_rdy = 1'($urandom_range(0, 1));
      hold = !g_rdy;
      pa = g_a; pb = g_b; pidx = g_idx;
      if (g_rdy) cnt++;
      cyc++;
      tick();
    end
    g_start = 1'b0;
    chk("dir_count", 32'(cnt), 32'd64);
    chk("dir_done", 32'(g_done), 32'h1);
    chk("dir_val_end", 32'(g_val), 32'h0);

    // ---- reset mid-stream, then RAND restart ----
    g_mode = 2'd0; g_rdy = 1'b1; g_start = 1'b1;
    tick();
    g_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_idx_before", g_idx, 32'd5);
    rst = 1'b1;
    #2;
    chk("mid_rst_a", g_a, 32'h0);
    chk("mid_rst_b", g_b, 32'h0);
    chk("mid_rst_val", 32'(g_val), 32'h0);
    chk("mid_rst_idx", g_idx, 32'h0);
    chk("mid_rst_done", 32'(g_done), 32'h0);
    tick();
    rst = 1'b0;
    g_mode = 2'd1; g_seed = 32'd1; g_start = 1'b1;
    tick();
    g_start = 1'b0;
    chk("restart_val", 32'(g_val), 32'h1);
    chk("restart_idx", g_idx, 32'h0);
    chk("restart_a", g_a, 32'h00042021);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
